// File: rtl/pll_reconf_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pll_reconf_ctrl_pkg : constants and types shared by ROM reader and scan engine
// Revision 1.0
// ---------------------------------------------------------------------------
package pll_reconf_ctrl_pkg;

  localparam int SCAN_LEN    = 144;
  localparam int ADDR_WIDTH  = 8;
  localparam int ROM_LATENCY = 2;
  localparam int TIMEOUT     = 4095;

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int CNT_W = $clog2(SCAN_LEN + 1);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SCAN_LEN - 1);
  localparam logic [TMO_W-1:0]      TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0]      TMO_MAX   = '1;
  // configupdate spans one scanclk period: two system clocks
  localparam logic [TMO_W-1:0]      UPD_LAST  = TMO_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_READ      = 3'd1,
    ST_WAIT_RCFG = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_UPDATE    = 3'd4,
    ST_WAIT_DONE = 3'd5
  } state_t;

  typedef struct packed {
    logic                  vld;
    logic [ADDR_WIDTH-1:0] addr;
  } rd_tag_t;

endpackage
`default_nettype wire

// File: rtl/pll_reconf_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pll_reconf_ctrl_if : ROM read port and ALTPLL scan/update port bundle
// Revision 1.0
// ---------------------------------------------------------------------------
interface pll_reconf_ctrl_if;
  import pll_reconf_ctrl_pkg::*;

  logic                  trigger_read;
  logic                  q;
  logic                  reconfig;
  logic                  scandone;
  logic [ADDR_WIDTH-1:0] address;
  logic                  read_ena;
  logic                  pll_reconf_busy;
  logic                  scanclk;
  logic                  scanclkena;
  logic                  scandata;
  logic                  configupdate;

  modport master (
    input  trigger_read, q, reconfig, scandone,
    output address, read_ena, pll_reconf_busy,
           scanclk, scanclkena, scandata, configupdate
  );

  modport slave (
    output trigger_read, q, reconfig, scandone,
    input  address, read_ena, pll_reconf_busy,
           scanclk, scanclkena, scandata, configupdate
  );

endinterface
`default_nettype wire

// File: rtl/pll_scan_serializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pll_scan_serializer : scan image buffer and scanclk/scandata shift engine
// Revision 1.0
// ---------------------------------------------------------------------------
module pll_scan_serializer
  import pll_reconf_ctrl_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic                  wr_data_i,
  input  logic                  start_i,
  output logic                  done_o,
  output logic                  scanclk_o,
  output logic                  scanclkena_o,
  output logic                  scandata_o
);

  logic [SCAN_LEN-1:0] buf_q;
  logic                active_q;
  logic                scanclk_q;
  logic                scandata_q;
  logic [CNT_W-1:0]    rise_q;

  // Done while the final high phase is showing, so the caller can switch
  // to update on the very edge that drops scanclk.
  assign done_o       = active_q & scanclk_q & (rise_q == CNT_W'(SCAN_LEN));
  assign scanclk_o    = scanclk_q;
  assign scanclkena_o = active_q;
  assign scandata_o   = scandata_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      buf_q      <= '0;
      active_q   <= 1'b0;
      scanclk_q  <= 1'b0;
      scandata_q <= 1'b0;
      rise_q     <= '0;
    end else begin
      if (wr_en_i && (wr_addr_i <= LAST_ADDR)) begin
        buf_q[wr_addr_i] <= wr_data_i;
      end
      if (start_i) begin
        active_q   <= 1'b1;
        scanclk_q  <= 1'b0;
        rise_q     <= '0;
        scandata_q <= buf_q[0];
      end else if (active_q) begin
        if (!scanclk_q) begin
          scanclk_q <= 1'b1;
          rise_q    <= rise_q + 1'b1;
        end else if (done_o) begin
          active_q   <= 1'b0;
          scanclk_q  <= 1'b0;
          scandata_q <= 1'b0;
        end else begin
          // falling scanclk: present the bit for the next rising edge
          scanclk_q  <= 1'b0;
          scandata_q <= buf_q[rise_q];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pll_reconf_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pll_reconf_ctrl : fetches a PLL scan image from the ROM and loads the PLL
// Revision 1.0
// ---------------------------------------------------------------------------
module pll_reconf_ctrl
  import pll_reconf_ctrl_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  pll_reconf_ctrl_if.master  bus,
  output logic               error
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [TMO_W-1:0]      tmo_q;
  logic                  error_q, error_d;
  logic [1:0]            sync_q;
  rd_tag_t               tag_q [ROM_LATENCY];
  logic                  ser_start;
  logic                  ser_done;
  logic                  read_ena_w;

  assign read_ena_w          = (state_q == ST_READ);
  assign bus.read_ena        = read_ena_w;
  assign bus.address         = addr_q;
  assign bus.pll_reconf_busy = (state_q != ST_IDLE);
  assign bus.configupdate    = (state_q == ST_UPDATE);
  assign error               = error_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    error_d   = error_q;
    ser_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.trigger_read) begin
          state_d = ST_READ;
          addr_d  = '0;
          error_d = 1'b0;
        end
      end
      ST_READ: begin
        if (addr_q == LAST_ADDR) state_d = ST_WAIT_RCFG;
        else                     addr_d  = addr_q + 1'b1;
      end
      ST_WAIT_RCFG: begin
        if (bus.reconfig) begin
          state_d   = ST_SHIFT;
          ser_start = 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_IDLE;
          error_d = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (ser_done) state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        if (tmo_q == UPD_LAST) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (sync_q[1]) begin
          state_d = ST_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_IDLE;
          error_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      error_q <= 1'b0;
      tmo_q   <= '0;
      sync_q  <= '0;
      for (int i = 0; i < ROM_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      error_q <= error_d;
      sync_q  <= {sync_q[0], bus.scandone};
      if (state_d != state_q)   tmo_q <= '0;
      else if (tmo_q != TMO_MAX) tmo_q <= tmo_q + 1'b1;
      // the tag emerging from this pipe names the bit q carries this clock
      tag_q[0] <= '{vld: read_ena_w, addr: addr_q};
      for (int i = 1; i < ROM_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  pll_scan_serializer u_ser (
    .clock        (clock),
    .reset_n      (reset_n),
    .wr_en_i      (tag_q[ROM_LATENCY-1].vld),
    .wr_addr_i    (tag_q[ROM_LATENCY-1].addr),
    .wr_data_i    (bus.q),
    .start_i      (ser_start),
    .done_o       (ser_done),
    .scanclk_o    (bus.scanclk),
    .scanclkena_o (bus.scanclkena),
    .scandata_o   (bus.scandata)
  );

endmodule
`default_nettype wire

// File: tb/tb_pll_reconf_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pll_reconf_ctrl : ROM + PLL models around pll_reconf_ctrl, table-driven
// ---------------------------------------------------------------------------
module tb_pll_reconf_ctrl;
  import pll_reconf_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  logic err;
  logic withhold = 1'b0;

  always #5 clk = ~clk;

  pll_reconf_ctrl_if bus ();

  pll_reconf_ctrl dut (
    .clock   (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .error   (err)
  );

  function automatic logic img(int a);
    logic [7:0] aa;
    aa = a[7:0];
    return aa[0] ^ aa[3];
  endfunction

  // ROM: two-clock read latency, reconfig pulse 3 clocks after read_ena falls
  logic [7:0] r_addr = '0;
  logic [3:0] hist   = '0;
  always @(posedge clk) begin
    r_addr <= bus.address;
    bus.q  <= img(int'(r_addr));
    hist   <= {hist[2:0], bus.read_ena};
  end
  assign bus.reconfig = hist[3] & ~hist[2] & ~withhold;

  // PLL: scandone rises 10 clocks after configupdate, held until busy drops
  int cu_cnt;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cu_cnt       <= 0;
      bus.scandone <= 1'b0;
    end else if (cu_cnt == 10) begin
      if (!bus.pll_reconf_busy) begin
        cu_cnt       <= 0;
        bus.scandone <= 1'b0;
      end
    end else if (cu_cnt != 0) begin
      cu_cnt <= cu_cnt + 1;
      if (cu_cnt == 9) bus.scandone <= 1'b1;
    end else if (bus.configupdate) begin
      cu_cnt <= 1;
    end
  end

  // Cumulative monitor; tests work on differences from a snapshot
  bit cap[$];
  int rise_cnt = 0, rd_cyc = 0, bursts = 0, cfg_cyc = 0, ena_cyc = 0, viol = 0;
  logic p_sclk = 0, p_re = 0, p_ena = 0, p_data = 0;
  always @(negedge clk) begin
    if (bus.scanclk && !p_sclk) begin
      cap.push_back(bus.scandata);
      rise_cnt++;
    end
    if (bus.read_ena) rd_cyc++;
    if (bus.read_ena && !p_re) bursts++;
    if (bus.configupdate) cfg_cyc++;
    if (bus.scanclkena) ena_cyc++;
    if (bus.scanclkena && p_ena && (bus.scandata != p_data) && !(p_sclk && !bus.scanclk)) viol++;
    p_sclk = bus.scanclk;
    p_re   = bus.read_ena;
    p_ena  = bus.scanclkena;
    p_data = bus.scandata;
  end

  int checks = 0, failures = 0;
  int b_rise, b_cap, b_rd, b_bursts, b_cfg, b_ena;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [14:0] outs();
    return {bus.address, bus.read_ena, bus.pll_reconf_busy, bus.scanclk,
            bus.scanclkena, bus.scandata, bus.configupdate, err};
  endfunction

  task automatic snap();
    b_rise = rise_cnt; b_cap = cap.size(); b_rd = rd_cyc;
    b_bursts = bursts; b_cfg = cfg_cyc; b_ena = ena_cyc;
  endtask

  task automatic pulse_trigger();
    @(negedge clk) bus.trigger_read = 1'b1;
    @(negedge clk) bus.trigger_read = 1'b0;
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    while (bus.pll_reconf_busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle"}, {31'd0, bus.pll_reconf_busy}, 32'd0);
  endtask

  task automatic check_run(string name);
    int mm = 0;
    for (int i = 0; i < SCAN_LEN; i++) begin
      if (b_cap + i >= cap.size())           mm++;
      else if (cap[b_cap + i] !== img(i))    mm++;
    end
    check({name, "_rises"},  rise_cnt - b_rise,  SCAN_LEN);
    check({name, "_image"},  mm,                 0);
    check({name, "_rdcyc"},  rd_cyc - b_rd,      SCAN_LEN);
    check({name, "_bursts"}, bursts - b_bursts,  1);
    check({name, "_cfgcyc"}, cfg_cyc - b_cfg,    2);
    check({name, "_err"},    {31'd0, err},       0);
  endtask

  typedef struct {
    int         cyc;
    logic [7:0] addr;
    logic       re, busy, sclkena, sclk, cfg, er;
  } vec_t;

  vec_t vecs [14];

  initial begin
    int cur;
    int n;
    vecs = '{
      '{  0,   0, 1, 1, 0, 0, 0, 0},
      '{  1,   1, 1, 1, 0, 0, 0, 0},
      '{ 77,  77, 1, 1, 0, 0, 0, 0},
      '{143, 143, 1, 1, 0, 0, 0, 0},
      '{144, 143, 0, 1, 0, 0, 0, 0},
      '{147, 143, 0, 1, 0, 0, 0, 0},
      '{148, 143, 0, 1, 1, 0, 0, 0},
      '{149, 143, 0, 1, 1, 1, 0, 0},
      '{435, 143, 0, 1, 1, 1, 0, 0},
      '{436, 143, 0, 1, 0, 0, 1, 0},
      '{437, 143, 0, 1, 0, 0, 1, 0},
      '{438, 143, 0, 1, 0, 0, 0, 0},
      '{448, 143, 0, 1, 0, 0, 0, 0},
      '{449, 143, 0, 0, 0, 0, 0, 0}
    };
    reset_n = 1'b0;
    bus.trigger_read = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs", {17'd0, outs()}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Run 1: cycle-accurate timeline relative to the trigger-sampling edge
    snap();
    pulse_trigger();
    cur = 0;
    for (int i = 0; i < 14; i++) begin
      while (cur < vecs[i].cyc) begin
        @(negedge clk);
        cur++;
      end
      check($sformatf("vec%0d_cyc%0d", i, vecs[i].cyc),
            {18'd0, bus.address, bus.read_ena, bus.pll_reconf_busy, bus.scanclkena,
             bus.scanclk, bus.configupdate, err},
            {18'd0, vecs[i].addr, vecs[i].re, vecs[i].busy, vecs[i].sclkena,
             vecs[i].sclk, vecs[i].cfg, vecs[i].er});
    end
    check_run("run1");
    check("scandata_stable", viol, 0);

    // Run 2: trigger during SHIFT must be ignored
    repeat (5) @(negedge clk);
    snap();
    pulse_trigger();
    n = 0;
    while (!bus.scanclkena && n < 1000) begin
      @(negedge clk);
      n++;
    end
    repeat (20) @(negedge clk);
    pulse_trigger();
    wait_idle("retrig");
    check_run("retrig");

    // Run 3: reconfig withheld -> timeout, then a clean recovery
    repeat (5) @(negedge clk);
    withhold = 1'b1;
    snap();
    pulse_trigger();
    n = 0;
    while (bus.read_ena && n < 400) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!err && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check("tmo_cycles", n, 4095);
    check("tmo_err",    {31'd0, err}, 1);
    check("tmo_busy",   {31'd0, bus.pll_reconf_busy}, 0);
    check("tmo_rises",  rise_cnt - b_rise, 0);
    check("tmo_ena",    ena_cyc - b_ena, 0);
    withhold = 1'b0;
    repeat (3) @(negedge clk);
    snap();
    pulse_trigger();
    check("err_clear", {31'd0, err}, 0);
    wait_idle("recover");
    check_run("recover");

    // Run 4: asynchronous reset at scan bit 70
    repeat (5) @(negedge clk);
    snap();
    pulse_trigger();
    n = 0;
    while ((rise_cnt - b_rise) < 70 && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("rst_at_bit70", rise_cnt - b_rise, 70);
    reset_n = 1'b0;
    #1;
    check("rst_async_outs", {17'd0, outs()}, 32'd0);
    repeat (3) @(negedge clk);
    check("rst_no_cfg", cfg_cyc - b_cfg, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    snap();
    pulse_trigger();
    wait_idle("after_rst");
    check_run("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
